vga_painter: RTL and testbench



---
 rtl/vga_painter.sv | 176 +++++++++++++++++
 tb/tb_vga_painter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vga_painter.sv
// 640x480@60 VGA painter drawing an MM:SS readout as seven-segment glyphs with a colon.
// Optional VGA_LATCH_EN: digits are captured once per frame at the start of vertical blank.
module vga_painter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] mDecimal,
  input  logic [3:0] mUnit,
  input  logic [3:0] sDecimal,
  input  logic [3:0] sUnit,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  localparam logic [9:0] BOX_TOP    = 10'd200;
  localparam logic [9:0] BOX_BOTTOM = 10'd279;
  localparam logic [9:0] BOX_WIDTH  = 10'd40;

  logic       tick_reg;
  logic [9:0] hc_reg, hc_next;
  logic [9:0] vc_reg, vc_next;
  logic       hsync_reg, vsync_reg;
  logic [2:0] rgb_reg;
  logic       hsync_next, vsync_next;
  logic [2:0] rgb_next;

  logic [3:0] digit_live [4];
  logic [3:0] digit_val  [4];
  logic [3:0] glyph_lit;
  logic       colon_lit;
  logic       visible;

  assign digit_live[0] = mDecimal;
  assign digit_live[1] = mUnit;
  assign digit_live[2] = sDecimal;
  assign digit_live[3] = sUnit;

  // Segment order {a,b,c,d,e,f,g}; codes 10..15 stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0000000;
    case (d)
      4'd0: s = 7'b1111110;
      4'd1: s = 7'b0110000;
      4'd2: s = 7'b1101101;
      4'd3: s = 7'b1111001;
      4'd4: s = 7'b0110011;
      4'd5: s = 7'b1011011;
      4'd6: s = 7'b1011111;
      4'd7: s = 7'b1110000;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= ~tick_reg;
    end
  end

  always_comb begin
    hc_next = hc_reg + 10'd1;
    vc_next = vc_reg;
    if (hc_reg == H_LAST) begin
      hc_next = 10'd0;
      vc_next = (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_reg <= 10'd0;
      vc_reg <= 10'd0;
    end else if (tick_reg) begin
      hc_reg <= hc_next;
      vc_reg <= vc_next;
    end
  end

`ifdef VGA_LATCH_EN
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
      logic [3:0] shadow_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          shadow_reg <= 4'd0;
        end else if (tick_reg && hc_reg == 10'd0 && vc_reg == V_VISIBLE) begin
          shadow_reg <= digit_live[gi];
        end
      end
      assign digit_val[gi] = shadow_reg;
    end
  endgenerate
`else
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_live
      assign digit_val[gi] = digit_live[gi];
    end
  endgenerate
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [9:0] LEFT = (gi == 0) ? 10'd220 :
                                    (gi == 1) ? 10'd270 :
                                    (gi == 2) ? 10'd330 : 10'd380;
      logic       in_box;
      logic [9:0] lx, ly;
      logic [6:0] segs, region;

      assign in_box = (hc_reg >= LEFT) && (hc_reg < LEFT + BOX_WIDTH) &&
                      (vc_reg >= BOX_TOP) && (vc_reg <= BOX_BOTTOM);
      assign lx   = hc_reg - LEFT;
      assign ly   = vc_reg - BOX_TOP;
      assign segs = seg_decode(digit_val[gi]);

      // Which segment areas the local pixel falls in; overlaps at corners are intended.
      assign region[6] = (ly <= 10'd7);
      assign region[5] = (lx >= 10'd32) && (ly <= 10'd39);
      assign region[4] = (lx >= 10'd32) && (ly >= 10'd40);
      assign region[3] = (ly >= 10'd72);
      assign region[2] = (lx <= 10'd7) && (ly >= 10'd40);
      assign region[1] = (lx <= 10'd7) && (ly <= 10'd39);
      assign region[0] = (ly >= 10'd36) && (ly <= 10'd43);

      assign glyph_lit[gi] = in_box && (|(segs & region));
    end
  endgenerate

  assign colon_lit = (hc_reg >= 10'd316) && (hc_reg <= 10'd323) &&
                     (((vc_reg >= 10'd220) && (vc_reg <= 10'd227)) ||
                      ((vc_reg >= 10'd252) && (vc_reg <= 10'd259)));

  assign visible = (hc_reg < H_VISIBLE) && (vc_reg < V_VISIBLE);

  always_comb begin
    rgb_next   = 3'b000;
    hsync_next = !((hc_reg >= H_SYNC_START) && (hc_reg <= H_SYNC_END));
    vsync_next = !((vc_reg >= V_SYNC_START) && (vc_reg <= V_SYNC_END));
    if (visible) begin
      rgb_next = ((|glyph_lit) || colon_lit) ? 3'b111 : 3'b001;
    end
  end

  // All three outputs register the same pre-edge position so they stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      rgb_reg   <= 3'b000;
    end else if (tick_reg) begin
      hsync_reg <= hsync_next;
      vsync_reg <= vsync_next;
      rgb_reg   <= rgb_next;
    end
  end

  assign hsync = hsync_reg;
  assign vsync = vsync_reg;
  assign rgb   = rgb_reg;

endmodule

// File: tb/tb_vga_painter.sv
// Directed bench for vga_painter: sync timing, pixel colours at fixed scan positions, resets.
// Scan position is derived from a clk count since reset release, not from the DUT.
`timescale 1ns/1ps
module tb_vga_painter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] mDecimal, mUnit, sDecimal, sUnit;
  logic       hsync, vsync;
  logic [2:0] rgb;

  int clk_count;
  int checks = 0;
  int errors = 0;

`ifdef VGA_LATCH_EN
  localparam logic [2:0] F0_AFTER_CHANGE = 3'b111;
  localparam logic [2:0] F1_AFTER_CHANGE = 3'b001;
`else
  localparam logic [2:0] F0_AFTER_CHANGE = 3'b001;
  localparam logic [2:0] F1_AFTER_CHANGE = 3'b111;
`endif

  vga_painter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mDecimal (mDecimal),
    .mUnit    (mUnit),
    .sDecimal (sDecimal),
    .sUnit    (sUnit),
    .hsync    (hsync),
    .vsync    (vsync),
    .rgb      (rgb)
  );

  always #10 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_count <= 0;
    else          clk_count <= clk_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Sample on the falling edge once the k-th rising edge since release has happened.
  task automatic wait_clk(input int k);
    while (clk_count < k) @(negedge clk);
  endtask

  // Pixel p of frame f is on rgb after rising edge 2*(f*420000 + p + 1).
  task automatic check_pixel(input string tag, input int f, input int x, input int y,
                             input logic [2:0] exp);
    wait_clk(2 * (f * 420000 + y * 800 + x + 1));
    check(tag, {29'd0, rgb}, {29'd0, exp});
  endtask

  initial begin
    #40_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    mDecimal = 4'd8;
    mUnit    = 4'd8;
    sDecimal = 4'd8;
    sUnit    = 4'd8;
    repeat (10) @(negedge clk);
    check("rst_hsync", {31'd0, hsync}, 32'd1);
    check("rst_vsync", {31'd0, vsync}, 32'd1);
    check("rst_rgb",   {29'd0, rgb},   32'd0);
    reset_n = 1'b1;

    // First line: latency, visible edge, hsync placement and width.
    wait_clk(1);    check("edge1_rgb",   {29'd0, rgb}, 32'd0);
    wait_clk(2);    check("px0_0",       {29'd0, rgb}, 32'd1);
    wait_clk(1280); check("px639_0",     {29'd0, rgb}, 32'd1);
    wait_clk(1282); check("px640_0",     {29'd0, rgb}, 32'd0);
    wait_clk(1313); check("hs_pre_fall", {31'd0, hsync}, 32'd1);
    wait_clk(1314); check("hs_fall",     {31'd0, hsync}, 32'd0);
    wait_clk(1505); check("hs_low_end",  {31'd0, hsync}, 32'd0);
    wait_clk(1506); check("hs_rise",     {31'd0, hsync}, 32'd1);
    wait_clk(2913); check("hs2_pre",     {31'd0, hsync}, 32'd1);
    wait_clk(2914); check("hs2_fall",    {31'd0, hsync}, 32'd0);

    // Frame 0: background, blanking, 8888 (or 0000 from reset shadows).
    check_pixel("f0_bg_100_10",    0, 100, 10, 3'b001);
    check_pixel("f0_blank_700_10", 0, 700, 10, 3'b000);
    check_pixel("f0_seg_a",        0, 225, 203, 3'b111);
    check_pixel("f0_interior8",    0, 240, 220, 3'b001);
    check_pixel("f0_colon",        0, 318, 222, 3'b111);
    mDecimal = 4'd1;
    mUnit    = 4'hA;
    sUnit    = 4'd1;
    check_pixel("f0_mu_after_chg", 0, 275, 230, F0_AFTER_CHANGE);
    check_pixel("f0_su_after_chg", 0, 385, 240, F0_AFTER_CHANGE);
    check_pixel("f0_md_after_chg", 0, 225, 250, F0_AFTER_CHANGE);
    check_pixel("f0_last_line",    0, 100, 479, 3'b001);
    check_pixel("f0_vblank",       0, 100, 480, 3'b000);

    wait_clk(784001); check("vs_pre_fall", {31'd0, vsync}, 32'd1);
    wait_clk(784002); check("vs_fall",     {31'd0, vsync}, 32'd0);
    wait_clk(787201); check("vs_low_end",  {31'd0, vsync}, 32'd0);
    wait_clk(787202); check("vs_rise",     {31'd0, vsync}, 32'd1);

    // Frame 1: digits 1, A, 8, 1 in both builds.
    check_pixel("f1_one_a_off",   1, 225, 203, 3'b001);
    check_pixel("f1_one_b_on",    1, 255, 203, 3'b111);
    check_pixel("f1_gap",         1, 265, 203, 3'b001);
    check_pixel("f1_code_a",      1, 275, 203, 3'b001);
    check_pixel("f1_eight_a",     1, 335, 203, 3'b111);
    check_pixel("f1_colon_left",  1, 315, 220, 3'b001);
    check_pixel("f1_colon_edge",  1, 316, 220, 3'b111);
    check_pixel("f1_colon",       1, 318, 222, 3'b111);
    check_pixel("f1_colon_gap",   1, 318, 228, 3'b001);
    check_pixel("f1_su_one",      1, 385, 240, 3'b001);
    sUnit = 4'd8;
    check_pixel("f1_su_mid_chg",  1, 385, 250, F1_AFTER_CHANGE);

    wait_clk(1624001); check("vs2_pre_fall", {31'd0, vsync}, 32'd1);
    wait_clk(1624002); check("vs2_fall",     {31'd0, vsync}, 32'd0);

    // Asynchronous reset in the middle of a visible line.
    check_pixel("f2_bg", 2, 100, 10, 3'b001);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rgb",   {29'd0, rgb},   32'd0);
    check("mid_rst_hsync", {31'd0, hsync}, 32'd1);
    check("mid_rst_vsync", {31'd0, vsync}, 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_clk(1);    check("re_edge1_rgb", {29'd0, rgb}, 32'd0);
    wait_clk(2);    check("re_px0_0",     {29'd0, rgb}, 32'd1);
    wait_clk(1313); check("re_hs_pre",    {31'd0, hsync}, 32'd1);
    wait_clk(1314); check("re_hs_fall",   {31'd0, hsync}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
